onehot_scan_decoder: RTL and testbench
======================================

# onehot_scan_decoder

Parametrised SEL_W-to-2^SEL_W one-hot decoder with registered outputs, selectable output polarity, and an autonomous scan mode. In scan mode the block steps through all channels with a programmable dwell time and optional blanking gap between channels. It drives LED/digit-select lines and generates walking-one stimulus for the analyzer.

## Interface
Parameters:
- SEL_W, 2, select width; output width N = 2^SEL_W (SEL_W 1..5).
- ACTIVE_LOW, 0, 1 = active channel driven 0 and inactive channels 1.
- DWELL_W, 16, width of the dwell-time input.
- BLANK, 0, inactive cycles inserted between channels in scan mode (0 = none).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = outputs driven; 0 = all channels inactive.
- mode  in  1  0 = direct decode of sel_in; 1 = auto scan.
- sel_in  in  SEL_W  channel select (direct mode) / scan start index.
- dwell  in  DWELL_W  on-cycles per channel in scan mode; 0 is treated as 1.
- out  out  N  registered one-hot (or one-cold) channel lines.
- cur_sel  out  SEL_W  index currently driven (or last driven, during blank/off).
- wrap  out  1  one-cycle pulse when scan returns to channel 0.

## Operation
- Inactive pattern IDLE_PAT = all 0 (ACTIVE_LOW=0) or all 1 (ACTIVE_LOW=1). Active pattern = bit cur_sel set to active level, all others inactive.
- FSM states: OFF, DIRECT, SCAN_ON, SCAN_BLANK.
- OFF: out = IDLE_PAT, counters held. Leave when en=1: to DIRECT if mode=0, else to SCAN_ON.
- DIRECT: each cycle cur_sel <= sel_in, out <= decode(sel_in). en=0 -> OFF; mode=1 -> SCAN_ON.
- Entry to SCAN_ON from OFF or DIRECT: cur_sel <= sel_in, dwell counter loaded with max(dwell,1).
- SCAN_ON: channel cur_sel active; counter decrements. On the last on-cycle: if BLANK>0 go to SCAN_BLANK, else advance index and reload the counter.
- SCAN_BLANK: out = IDLE_PAT for exactly BLANK cycles, then advance index and enter SCAN_ON.
- Advance: cur_sel <= cur_sel+1, mod N (N-1 wraps to 0). wrap=1 for the first on-cycle of channel 0 reached by advance only. Entry at sel_in=0 does not pulse wrap.
- dwell is sampled only at the start of each channel's on-period. A mid-channel change applies from the next channel.
- From SCAN_ON/SCAN_BLANK: en=0 -> OFF (out idle next cycle); mode=0 -> DIRECT (decode sel_in next cycle). Priority: rst > en=0 > mode change > scan sequencing.
- Reset: state OFF, out = IDLE_PAT, cur_sel = 0, wrap = 0, dwell and blank counters 0.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Direct mode: sel_in sampled at edge k appears on out/cur_sel after edge k (1-cycle latency).
- Scan period per channel = max(dwell,1) + BLANK cycles; full frame = N × that.
- en or mode change sampled at edge k takes effect on out after edge k.
- Reset asserted mid-scan: out = IDLE_PAT after the next edge, regardless of other inputs.
- wrap is coincident with the out update that selects channel 0.

## Structure
- Shared package (analyzer_pkg): FSM state encoding localparams and an IDLE_PAT helper function of (N, ACTIVE_LOW), reused by later select/stimulus blocks.
- One sub-module: onehot_decode (combinational, parameters SEL_W and ACTIVE_LOW, input index and valid, output N lines; valid=0 gives IDLE_PAT). The top level registers its output.
- Counters: dwell counter of DWELL_W bits, blank counter of clog2(BLANK+1) bits (omitted when BLANK=0).

## Test plan
- Reset with SEL_W=2, ACTIVE_LOW=0: rst high 3 cycles -> out=4'b0000, cur_sel=0, wrap=0. Repeat with ACTIVE_LOW=1 -> out=4'b1111.
- Direct sweep: en=1, mode=0, sel_in=0,1,2,3 on consecutive cycles -> out=0001,0010,0100,1000, each one cycle later. ACTIVE_LOW=1 -> 1110,1101,1011,0111.
- Scan, dwell=3, BLANK=0, sel_in=2 at entry -> channel 2 for 3 cycles, then 3, then 0 with wrap=1 for one cycle, then 1. Frame = 12 cycles.
- Scan, dwell=0, BLANK=2 -> each channel active 1 cycle followed by 2 idle cycles. Frame = 12 cycles.
- Dwell change mid-channel (5 -> 2 during channel 1) -> channel 1 stays active 5 cycles, channel 2 active 2 cycles.
- Interruptions during scan: en=0 -> idle next cycle, cur_sel held; mode=0 with sel_in=1 -> out=0010 next cycle; rst mid-blank -> reset values next cycle.

Source files
------------

// File: rtl/onehot_scan_decoder_pkg.sv
// Shared definitions for the analyzer select/stimulus blocks: FSM state
// encoding and the idle (all-inactive) output pattern helper.
package onehot_scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN_ON,
        ST_SCAN_BLANK
    } state_e;

    // Lines 0..n-1 carry the inactive level; upper bits are zero padding.
    function automatic logic [31:0] idle_pat(input int unsigned n, input bit active_low);
        logic [31:0] p;
        p = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) p[i] = active_low;
        end
        return p;
    endfunction

endpackage

// File: rtl/onehot_scan_decoder_decode.sv
// Combinational SEL_W-to-2^SEL_W decoder with selectable polarity;
// valid_i low yields the idle pattern.
module onehot_decode
    import onehot_scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic [SEL_W-1:0]      idx_i,
    input  logic                  valid_i,
    output logic [(2**SEL_W)-1:0] lines_o
);

    localparam int unsigned N = 2 ** SEL_W;
    localparam logic [31:0]  IDLE_FULL = idle_pat(N, ACTIVE_LOW);
    localparam logic [N-1:0] IDLE_PAT  = IDLE_FULL[N-1:0];

    always_comb begin
        lines_o = IDLE_PAT;
        if (valid_i) lines_o[idx_i] = ~ACTIVE_LOW;
    end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot channel decoder with direct-select and autonomous scan
// modes (programmable dwell, optional blanking gap between channels).
module onehot_scan_decoder
    import onehot_scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter int unsigned DWELL_W    = 16,
    parameter int unsigned BLANK      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] out,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  wrap
);

    localparam int unsigned N = 2 ** SEL_W;
    localparam logic [31:0]  IDLE_FULL = idle_pat(N, ACTIVE_LOW);
    localparam logic [N-1:0] IDLE_PAT  = IDLE_FULL[N-1:0];

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d, sel_next;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d, dwell_eff;
    logic [N-1:0]       out_q, dec_lines;
    logic               wrap_q, wrap_d;
    logic               dec_valid, advance;
    logic               blank_load, blank_dec, blank_last;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign sel_next  = cur_sel_q + SEL_W'(1);

    // Priority: en=0, then mode=0 (direct), then scan sequencing.
    always_comb begin
        state_d     = state_q;
        cur_sel_d   = cur_sel_q;
        dwell_cnt_d = dwell_cnt_q;
        wrap_d      = 1'b0;
        dec_valid   = 1'b0;
        advance     = 1'b0;
        blank_load  = 1'b0;
        blank_dec   = 1'b0;

        if (!en) begin
            state_d = ST_OFF;
        end else if (!mode) begin
            state_d   = ST_DIRECT;
            cur_sel_d = sel_in;
            dec_valid = 1'b1;
        end else begin
            unique case (state_q)
                ST_OFF, ST_DIRECT: begin
                    state_d     = ST_SCAN_ON;
                    cur_sel_d   = sel_in;
                    dwell_cnt_d = dwell_eff;
                    dec_valid   = 1'b1;
                end
                ST_SCAN_ON: begin
                    if (dwell_cnt_q > DWELL_W'(1)) begin
                        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                        dec_valid   = 1'b1;
                    end else if (BLANK > 0) begin
                        state_d    = ST_SCAN_BLANK;
                        blank_load = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_SCAN_BLANK: begin
                    if (blank_last) advance   = 1'b1;
                    else            blank_dec = 1'b1;
                end
                default: state_d = ST_OFF;
            endcase

            if (advance) begin
                state_d     = ST_SCAN_ON;
                cur_sel_d   = sel_next;
                dwell_cnt_d = dwell_eff;
                dec_valid   = 1'b1;
                wrap_d      = (sel_next == '0);
            end
        end
    end

    // Decoding the next index lets the output register hold final line values.
    onehot_decode #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decode (
        .idx_i   (cur_sel_d),
        .valid_i (dec_valid),
        .lines_o (dec_lines)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OFF;
            cur_sel_q   <= '0;
            dwell_cnt_q <= '0;
            out_q       <= IDLE_PAT;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            dwell_cnt_q <= dwell_cnt_d;
            out_q       <= dec_lines;
            wrap_q      <= wrap_d;
        end
    end

    generate
        if (BLANK > 0) begin : g_blank
            localparam int unsigned BW = $clog2(BLANK + 1);
            logic [BW-1:0] blank_cnt_q;

            always_ff @(posedge clk) begin
                if (rst)             blank_cnt_q <= '0;
                else if (blank_load) blank_cnt_q <= BW'(BLANK);
                else if (blank_dec)  blank_cnt_q <= blank_cnt_q - BW'(1);
            end

            assign blank_last = (blank_cnt_q == BW'(1));
        end else begin : g_no_blank
            logic unused_blank;
            assign unused_blank = blank_load | blank_dec;
            assign blank_last   = 1'b0;
        end
    endgenerate

    assign out     = out_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

    // Lines are either idle or differ from idle in exactly one position.
    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(out_q ^ IDLE_PAT));
    a_wrap_ch0: assert property (@(posedge clk) disable iff (rst)
        wrap_q |-> (cur_sel_q == '0));

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboard bench: three decoder variants share stimulus; expected
// responses are queued per cycle and popped by an independent monitor.
module tb_onehot_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel_in = '0;
    logic [15:0] dwell = '0;

    logic [3:0] out0, out1, out2;
    logic [1:0] cs0, cs1, cs2;
    logic       w0, w1, w2;

    always #5 clk = ~clk;

    onehot_scan_decoder #(.SEL_W(2), .ACTIVE_LOW(1'b0), .DWELL_W(16), .BLANK(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .dwell(dwell),
        .out(out0), .cur_sel(cs0), .wrap(w0));
    onehot_scan_decoder #(.SEL_W(2), .ACTIVE_LOW(1'b1), .DWELL_W(16), .BLANK(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .dwell(dwell),
        .out(out1), .cur_sel(cs1), .wrap(w1));
    onehot_scan_decoder #(.SEL_W(2), .ACTIVE_LOW(1'b0), .DWELL_W(16), .BLANK(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .dwell(dwell),
        .out(out2), .cur_sel(cs2), .wrap(w2));

    typedef struct {
        int unsigned cyc;
        int unsigned d;
        logic [3:0]  o;
        logic [1:0]  s;
        logic        w;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic        done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // dwell=3, BLANK=0, entry at channel 2
    localparam logic [3:0] T3O [13] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000,
        4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    localparam logic [1:0] T3S [13] = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1, 1, 1, 2};
    // dwell=3, BLANK=2, entry at channel 2
    localparam logic [3:0] T3BO [13] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000,
        4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
    localparam logic [1:0] T3BS [13] = '{2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 0, 0, 0};
    // dwell=0, BLANK=0, entry at channel 0
    localparam logic [3:0] T4O [13] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
        4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [1:0] T4S [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    localparam logic       T4W [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    // dwell=0, BLANK=2, entry at channel 0
    localparam logic [3:0] T4BO [13] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
        4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
    localparam logic [1:0] T4BS [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    // dwell 5 changed to 2 during channel 1
    localparam logic [3:0] T5O [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
        4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    localparam logic [1:0] T5S [10] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 0};
    localparam logic [3:0] TDIR [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] ao;
        logic [1:0] as;
        logic       aw;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.d)
                0:       begin ao = out0; as = cs0; aw = w0; end
                1:       begin ao = out1; as = cs1; aw = w1; end
                default: begin ao = out2; as = cs2; aw = w2; end
            endcase
            checks++;
            if (e.cyc != cyc || ao !== e.o || as !== e.s || aw !== e.w) begin
                errors++;
                $display("FAIL %s dut%0d cyc%0d: got out=%b cur_sel=%0d wrap=%b, want out=%b cur_sel=%0d wrap=%b (at cyc%0d)",
                         e.nm, e.d, e.cyc, ao, as, aw, e.o, e.s, e.w, cyc);
            end
        end
        if (done) begin
            if (sb.size() > 0) begin
                checks += sb.size();
                errors += sb.size();
                $display("FAIL drain: %0d expected responses never compared, want 0", sb.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic drive(input logic r, input logic e, input logic m,
                         input logic [1:0] s, input logic [15:0] dw);
        rst = r; en = e; mode = m; sel_in = s; dwell = dw;
    endtask

    task automatic expect_d(input int unsigned d, input logic [3:0] o, input logic [1:0] s,
                            input logic w, input string nm);
        exp_t x;
        x.cyc = cyc + 1; x.d = d; x.o = o; x.s = s; x.w = w; x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic expect_all(input logic [3:0] o, input logic [1:0] s, input logic w,
                              input string nm);
        expect_d(0, o, s, w, nm);
        expect_d(1, ~o, s, w, nm);
        expect_d(2, o, s, w, nm);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 2'd3, 16'd0);
            expect_all(4'b0000, 2'd0, 1'b0, "reset");
            step();
        end

        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 2'(i), 16'd0);
            expect_all(TDIR[i], 2'(i), 1'b0, "direct");
            step();
        end

        for (int i = 0; i < 13; i++) begin
            drive(0, 1, 1, 2'd2, 16'd3);
            expect_d(0, T3O[i], T3S[i], (i == 6), "scan_d3");
            expect_d(1, ~T3O[i], T3S[i], (i == 6), "scan_d3_al");
            expect_d(2, T3BO[i], T3BS[i], (i == 10), "scan_d3_blank2");
            step();
        end

        drive(0, 1, 0, 2'd0, 16'd0);
        expect_all(4'b0001, 2'd0, 1'b0, "direct_ch0");
        step();
        for (int i = 0; i < 13; i++) begin
            drive(0, 1, 1, 2'd0, 16'd0);
            expect_d(0, T4O[i], T4S[i], T4W[i], "scan_d0");
            expect_d(2, T4BO[i], T4BS[i], (i == 12), "scan_d0_blank2");
            step();
        end

        drive(0, 1, 0, 2'd1, 16'd0);
        expect_all(4'b0010, 2'd1, 1'b0, "direct_ch1");
        step();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 2'd1, (i >= 2) ? 16'd2 : 16'd5);
            expect_d(0, T5O[i], T5S[i], (i == 9), "dwell_change");
            step();
        end

        drive(0, 0, 1, 2'd1, 16'd2);
        expect_d(0, 4'b0000, 2'd0, 1'b0, "en_off");
        expect_d(1, 4'b1111, 2'd0, 1'b0, "en_off_al");
        step();
        drive(0, 1, 1, 2'd3, 16'd4);
        expect_all(4'b1000, 2'd3, 1'b0, "scan_entry3");
        step();
        drive(0, 1, 0, 2'd1, 16'd4);
        expect_all(4'b0010, 2'd1, 1'b0, "scan_to_direct");
        step();
        drive(0, 1, 1, 2'd2, 16'd1);
        expect_all(4'b0100, 2'd2, 1'b0, "scan_entry2");
        step();
        drive(0, 1, 1, 2'd2, 16'd1);
        expect_d(0, 4'b1000, 2'd3, 1'b0, "scan_adv");
        expect_d(1, 4'b0111, 2'd3, 1'b0, "scan_adv_al");
        expect_d(2, 4'b0000, 2'd2, 1'b0, "blank_idle");
        step();
        drive(1, 1, 1, 2'd2, 16'd1);
        expect_all(4'b0000, 2'd0, 1'b0, "rst_mid_blank");
        step();
        drive(0, 0, 0, 2'd0, 16'd0);
        expect_all(4'b0000, 2'd0, 1'b0, "off_after_rst");
        step();

        step();
        step();
        done = 1'b1;
    end

endmodule
